lr_div_33s_18s_seq: RTL and testbench

Sequential radix-2 signed divider: 33-bit signed dividend by 18-bit signed divisor. It is the inverse of the 17ns x 18s -> 33s multiply used in the LR fit datapath; it recovers slope/intercept terms from accumulated products. It uses a valid/ready handshake on both sides and handles one operation at a time. Results follow C semantics: truncation toward zero, and the remainder takes the sign of the dividend.

---
 rtl/lr_div_pkg.sv | 31 +++
 rtl/lr_div_abs.sv | 23 ++
 rtl/lr_div_33s_18s_seq.sv | 178 +++++++++++++++++
 tb/tb_lr_div_33s_18s_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lr_div_pkg.sv
// ============================================================================
//  Module   : lr_div_pkg
//  Purpose  : Shared types and constants for the LR-fit sequential signed
//             divider (33s / 18s).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lr_div_pkg;

  // Default operand widths: dividend/quotient and divisor/remainder
  localparam int DVD_W_DEF = 33;
  localparam int DVS_W_DEF = 18;

  // Iteration counter width, enough to hold DVD_W-1
  localparam int CNT_W_DEF = $clog2(DVD_W_DEF);

  // Saturation values used for divide-by-zero and overflow results
  localparam logic [DVD_W_DEF-1:0] QMAX = {1'b0, {(DVD_W_DEF-1){1'b1}}};
  localparam logic [DVD_W_DEF-1:0] QMIN = {1'b1, {(DVD_W_DEF-1){1'b0}}};

  // Controller states, encoded explicitly
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage : lr_div_pkg

`default_nettype wire

// File: rtl/lr_div_abs.sv
// ============================================================================
//  Module   : lr_div_abs
//  Purpose  : Combinational signed-to-magnitude converter. The magnitude is
//             produced as a W-bit unsigned value so |-2^(W-1)| = 2^(W-1) is
//             represented exactly.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lr_div_abs #(
  parameter int W = 18
) (
  input  logic [W-1:0] a,
  output logic         neg,
  output logic [W-1:0] mag
);

  assign neg = a[W-1];
  assign mag = neg ? (~a + 1'b1) : a;

endmodule : lr_div_abs

`default_nettype wire

// File: rtl/lr_div_33s_18s_seq.sv
// ============================================================================
//  Module   : lr_div_33s_18s_seq
//  Purpose  : Sequential radix-2 restoring signed divider, 33s / 18s, with
//             valid/ready handshakes. C semantics: quotient truncates toward
//             zero, remainder carries the sign of the dividend.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lr_div_33s_18s_seq
  import lr_div_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DVD_W-1:0] dividend,
  input  logic signed [DVS_W-1:0] divisor,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DVD_W-1:0] quotient,
  output logic signed [DVS_W-1:0] remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int               CNT_W  = $clog2(DVD_W);
  localparam logic [DVD_W-1:0] c_qmax = {1'b0, {(DVD_W-1){1'b1}}};
  localparam logic [DVD_W-1:0] c_qmin = {1'b1, {(DVD_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(DVD_W - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sq;     // quotient sign
  logic             r_sr;     // remainder sign (= dividend sign)
  logic [DVD_W-1:0] r_dvd;    // |dividend|, shifted out MSB first; fills with |q|
  logic [DVS_W-1:0] r_dvs;    // |divisor|
  logic [DVS_W:0]   r_pr;     // partial remainder

  logic [DVD_W-1:0] r_quotient;
  logic [DVS_W-1:0] r_remainder;
  logic             r_dbz;
  logic             r_ovf;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [DVD_W-1:0] w_dvd_mag;
  logic [DVS_W-1:0] w_dvs_mag;
  logic             w_accept;
  logic             w_dvs_zero;
  logic [DVS_W:0]   w_pr_sh;
  logic             w_ge;
  logic [DVS_W:0]   w_pr_sub;
  logic [DVD_W-1:0] w_q_signed;
  logic [DVS_W-1:0] w_r_signed;
  logic             w_ovf;

  lr_div_abs #(.W(DVD_W)) u_abs_dvd (
    .a   (dividend),
    .neg (w_dvd_neg),
    .mag (w_dvd_mag)
  );

  lr_div_abs #(.W(DVS_W)) u_abs_dvs (
    .a   (divisor),
    .neg (w_dvs_neg),
    .mag (w_dvs_mag)
  );

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_dvs_zero = (divisor == '0);

  // Restoring step: bring down the next dividend bit, then trial-subtract.
  // The bit shifted out of the partial remainder joins the comparison; it is
  // always zero because pr < |dvs| before every shift.
  assign w_pr_sh  = {r_pr[DVS_W-1:0], r_dvd[DVD_W-1]};
  assign w_ge     = r_pr[DVS_W] | (w_pr_sh >= {1'b0, r_dvs});
  assign w_pr_sub = w_pr_sh - {1'b0, r_dvs};

  // Sign re-application; |q| can reach 2^(DVD_W-1), which only fits when the
  // quotient is negative, so a positive quotient with the top bit set overflows
  assign w_q_signed = r_sq ? (~r_dvd + 1'b1) : r_dvd;
  assign w_r_signed = r_sr ? (~r_pr[DVS_W-1:0] + 1'b1) : r_pr[DVS_W-1:0];
  assign w_ovf      = ~r_sq & r_dvd[DVD_W-1];

  // Controller: state sequencing and iteration counter
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_dvs_zero) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
              r_cnt   <= c_cnt_init;
            end
          end
        end
        ST_CALC: begin
          if (r_cnt == '0) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_FIX: begin
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Operand capture and one quotient bit per CALC cycle
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_sq  <= 1'b0;
      r_sr  <= 1'b0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_pr  <= '0;
    end else if (w_accept) begin
      r_sq  <= w_dvd_neg ^ w_dvs_neg;
      r_sr  <= w_dvd_neg;
      r_dvd <= w_dvd_mag;
      r_dvs <= w_dvs_mag;
      r_pr  <= '0;
    end else if (r_state == ST_CALC) begin
      r_pr  <= w_ge ? w_pr_sub : w_pr_sh;
      r_dvd <= {r_dvd[DVD_W-2:0], w_ge};
    end
  end

  // Result registers: loaded on divide-by-zero accept or in FIX, held otherwise
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept) begin
      r_dbz <= w_dvs_zero;
      r_ovf <= 1'b0;
      if (w_dvs_zero) begin
        r_quotient  <= w_dvd_neg ? c_qmin : c_qmax;
        r_remainder <= '0;
      end
    end else if (r_state == ST_FIX) begin
      r_ovf       <= w_ovf;
      r_quotient  <= w_ovf ? c_qmax : w_q_signed;
      r_remainder <= w_r_signed;
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule : lr_div_33s_18s_seq

`default_nettype wire

// File: tb/tb_lr_div_33s_18s_seq.sv
// ============================================================================
//  Module   : tb_lr_div_33s_18s_seq
//  Purpose  : Directed and randomized self-checking bench for the 33s/18s
//             sequential divider.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lr_div_33s_18s_seq;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] dividend;
  logic [17:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] quotient;
  logic [17:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int n_chk;
  int n_fail;

  logic [32:0]        hold_q;
  logic [17:0]        hold_r;
  logic signed [32:0] rs_a;
  logic signed [17:0] rs_b;
  longint             m_a;
  longint             m_b;
  longint             m_q;
  longint             m_r;
  logic [32:0]        m_eq;
  logic [17:0]        m_er;
  logic               m_dbz;
  logic               m_ovf;

  lr_div_33s_18s_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure edges from accept to out_valid, check result
  task automatic run_op(input string tag, input logic [32:0] a, input logic [17:0] b,
                        input logic [32:0] eq, input logic [17:0] er,
                        input logic edz, input logic eov, input int elat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge ap_clk); #1; n++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge ap_clk); #1; n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(elat));
    chk({tag, "_q"},   quotient, eq);
    chk({tag, "_r"},   remainder, er);
    chk({tag, "_dbz"}, div_by_zero, edz);
    chk({tag, "_ovf"}, overflow, eov);
  endtask

  // Consume the result and confirm the divider returns to IDLE
  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ovdrop"}, out_valid, 1'b0);
    chk({tag, "_rdy"},    in_ready,  1'b1);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset state
    #12;
    chk("rst_in_ready",  in_ready,    1'b1);
    chk("rst_out_valid", out_valid,   1'b0);
    chk("rst_q",         quotient,    33'd0);
    chk("rst_r",         remainder,   18'd0);
    chk("rst_dbz",       div_by_zero, 1'b0);
    chk("rst_ovf",       overflow,    1'b0);
    #5 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Sign combinations of 100 / 7
    run_op("pp", 33'd100,  18'd7,  33'd14,  18'd2,  1'b0, 1'b0, 35); take_result("pp");
    run_op("np", -33'd100, 18'd7,  -33'd14, -18'd2, 1'b0, 1'b0, 35); take_result("np");
    run_op("pn", 33'd100,  -18'd7, -33'd14, 18'd2,  1'b0, 1'b0, 35); take_result("pn");
    run_op("nn", -33'd100, -18'd7, 33'd14,  -18'd2, 1'b0, 1'b0, 35); take_result("nn");

    // Extremes
    run_op("ovf",  33'h1_0000_0000, -18'd1, 33'h0_FFFF_FFFF, 18'd0, 1'b0, 1'b1, 35);
    take_result("ovf");
    run_op("min1", 33'h1_0000_0000, 18'd1,  33'h1_0000_0000, 18'd0, 1'b0, 1'b0, 35);
    take_result("min1");
    run_op("maxd", 33'h0_FFFF_FFFF, 18'h2_0000, -33'd32767, 18'd131071, 1'b0, 1'b0, 35);
    take_result("maxd");

    // Divide by zero
    run_op("dz_p", 33'd5,  18'd0, 33'h0_FFFF_FFFF, 18'd0, 1'b1, 1'b0, 1); take_result("dz_p");
    run_op("dz_n", -33'd5, 18'd0, 33'h1_0000_0000, 18'd0, 1'b1, 1'b0, 1); take_result("dz_n");

    // Backpressure: hold DONE for 10 cycles, offer a new operation mid-stall
    run_op("bp", 33'd30, 18'd4, 33'd7, 18'd2, 1'b0, 1'b0, 35);
    hold_q = quotient;
    hold_r = remainder;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        dividend = 33'd77;
        divisor  = 18'd0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge ap_clk); #1;
      chk("bp_ov",  out_valid,   1'b1);
      chk("bp_rdy", in_ready,    1'b0);
      chk("bp_q",   quotient,    33'd7);
      chk("bp_r",   remainder,   18'd2);
      chk("bp_dbz", div_by_zero, 1'b0);
    end
    in_valid = 1'b0;
    take_result("bp");
    chk("bp_hold_q", quotient, hold_q);
    chk("bp_hold_r", remainder, hold_r);
    run_op("bp_next", 33'd1000, 18'd3, 33'd333, 18'd1, 1'b0, 1'b0, 35); take_result("bp_next");

    // Reset mid-CALC; a divide-by-zero offered during CALC must be ignored
    dividend = 33'd100;
    divisor  = 18'd7;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        dividend = 33'd7;
        divisor  = 18'd0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge ap_clk); #1;
      chk("calc_ov", out_valid, 1'b0);
      chk("calc_rdy", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    #1 ap_rst_n = 1'b0;
    #1;
    chk("mrst_ov",  out_valid, 1'b0);
    chk("mrst_rdy", in_ready,  1'b1);
    chk("mrst_q",   quotient,  33'd0);
    @(posedge ap_clk); #3;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    chk("mrst_idle_ov", out_valid, 1'b0);
    run_op("after_rst", 33'd21, 18'd4, 33'd5, 18'd1, 1'b0, 1'b0, 35); take_result("after_rst");

    // Random sweep against a C-semantics model
    for (int k = 0; k < 200; k++) begin
      case (k % 8)
        0:       rs_b = 18'sd0;
        1:       rs_b = 18'($urandom_range(0, 15)) - 18'sd8;
        2:       rs_b = 18'sh20000;
        default: rs_b = 18'($urandom());
      endcase
      if (k % 16 == 5) rs_a = 33'sh1_0000_0000;
      else             rs_a = {1'($urandom_range(0, 1)), 32'($urandom())};
      if (k == 7) rs_b = -18'sd1;
      if (k == 7) rs_a = 33'sh1_0000_0000;
      m_a = rs_a;
      m_b = rs_b;
      m_dbz = 1'b0;
      m_ovf = 1'b0;
      if (m_b == 0) begin
        m_dbz = 1'b1;
        m_eq  = (m_a < 0) ? 33'h1_0000_0000 : 33'h0_FFFF_FFFF;
        m_er  = 18'd0;
      end else if (m_a == -64'sd4294967296 && m_b == -64'sd1) begin
        m_ovf = 1'b1;
        m_eq  = 33'h0_FFFF_FFFF;
        m_er  = 18'd0;
      end else begin
        m_q  = m_a / m_b;
        m_r  = m_a % m_b;
        m_eq = m_q[32:0];
        m_er = m_r[17:0];
      end
      run_op("rnd", rs_a, rs_b, m_eq, m_er, m_dbz, m_ovf, m_dbz ? 1 : 35);
      take_result("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_lr_div_33s_18s_seq

`default_nettype wire
